// File: rtl/sap1_pkg.sv
// Shared constants and the control-word layout for the SAP-1 controller-sequencer.
package sap1_pkg;

    localparam int OPC_W   = 4;
    localparam int T_COUNT = 6;

    localparam logic [OPC_W-1:0] OP_LDA = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADD = 4'h1;
    localparam logic [OPC_W-1:0] OP_SUB = 4'h2;
    localparam logic [OPC_W-1:0] OP_OUT = 4'hE;
    localparam logic [OPC_W-1:0] OP_HLT = 4'hF;

    // Bit positions of each T-state in the one-hot ring
    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } ctrl_word_t;

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T-state ring with a sticky halted flag and an early-restart input.
module sap1_ring_counter #(
    parameter int RING_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              halt_req,
    input  logic              restart,
    output logic [RING_W-1:0] t_state,
    output logic              halted
);

    logic [RING_W-1:0] ring_q, ring_d;
    logic              halted_q, halted_d;

    always_comb begin
        ring_d   = ring_q;
        halted_d = halted_q;
        // Once halted the ring stays frozen at the state where HLT was decoded
        if (!halted_q) begin
            if (halt_req) begin
                halted_d = 1'b1;
            end else if (restart) begin
                ring_d = {{(RING_W-1){1'b0}}, 1'b1};
            end else begin
                ring_d = {ring_q[RING_W-2:0], ring_q[RING_W-1]};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ring_q   <= {{(RING_W-1){1'b0}}, 1'b1};
            halted_q <= 1'b0;
        end else begin
            ring_q   <= ring_d;
            halted_q <= halted_d;
        end
    end

    assign t_state = ring_q;
    assign halted  = halted_q;

endmodule

// File: rtl/sap1_controller.sv
// SAP-1 controller-sequencer: decodes T-state and opcode into the bus control word.
// Define SAP1_EARLY_END_EN to shorten machine cycles to the last useful T-state.
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int RING_W   = 6
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [RING_W-1:0]   t_state,
    output logic                cp,
    output logic                ep,
    output logic                lm,
    output logic                ce,
    output logic                li,
    output logic                ei,
    output logic                la,
    output logic                ea,
    output logic                su,
    output logic                eu,
    output logic                lb,
    output logic                lo,
    output logic                halt
);

    ctrl_word_t cw;
    logic       halt_req;
    logic       restart;
    logic       halted;

    sap1_ring_counter #(
        .RING_W (RING_W)
    ) u_ring (
        .clock    (clock),
        .reset    (reset),
        .halt_req (halt_req),
        .restart  (restart),
        .t_state  (t_state),
        .halted   (halted)
    );

    always_comb begin
        cw       = '0;
        halt_req = 1'b0;
        restart  = 1'b0;

        if (t_state[T1]) begin
            cw.ep = 1'b1;
            cw.lm = 1'b1;
        end
        if (t_state[T2]) begin
            cw.cp = 1'b1;
        end
        if (t_state[T3]) begin
            cw.ce = 1'b1;
            cw.li = 1'b1;
        end
        if (t_state[T4]) begin
            case (opcode)
                OP_LDA, OP_ADD, OP_SUB: begin
                    cw.lm = 1'b1;
                    cw.ei = 1'b1;
                end
                OP_OUT: begin
                    cw.ea = 1'b1;
                    cw.lo = 1'b1;
                end
                OP_HLT:  halt_req = 1'b1;
                default: ;
            endcase
        end
        if (t_state[T5]) begin
            case (opcode)
                OP_LDA: begin
                    cw.ce = 1'b1;
                    cw.la = 1'b1;
                end
                OP_ADD, OP_SUB: begin
                    cw.ce = 1'b1;
                    cw.lb = 1'b1;
                end
                default: ;
            endcase
        end
        if (t_state[T6]) begin
            if (opcode == OP_ADD || opcode == OP_SUB) begin
                cw.la = 1'b1;
                cw.eu = 1'b1;
                cw.su = (opcode == OP_SUB);
            end
        end

`ifdef SAP1_EARLY_END_EN
        // OUT and NOPs finish at T4, LDA at T5; HLT is handled by the freeze
        if (t_state[T4] && opcode != OP_LDA && opcode != OP_ADD &&
            opcode != OP_SUB && opcode != OP_HLT) begin
            restart = 1'b1;
        end
        if (t_state[T5] && opcode == OP_LDA) begin
            restart = 1'b1;
        end
`endif

        if (!reset || halted) begin
            cw = '0;
        end
    end

    assign cp   = cw.cp;
    assign ep   = cw.ep;
    assign lm   = cw.lm;
    assign ce   = cw.ce;
    assign li   = cw.li;
    assign ei   = cw.ei;
    assign la   = cw.la;
    assign ea   = cw.ea;
    assign su   = cw.su;
    assign eu   = cw.eu;
    assign lb   = cw.lb;
    assign lo   = cw.lo;
    assign halt = reset && (halted || halt_req);

    bus_exclusive_a: assert property (@(posedge clock) disable iff (!reset)
        $onehot0({ep, ce, ei, ea, eu}));

endmodule

// File: tb/tb_sap1_controller.sv
// Directed bench for sap1_controller; expected strobes are hand-written constants.
module tb_sap1_controller;

    logic       clock;
    logic       reset;
    logic [3:0] opcode;
    logic [5:0] t_state;
    logic       cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, halt;

    int total = 0;
    int bad   = 0;

    localparam logic [12:0] S_CP   = 13'h1000;
    localparam logic [12:0] S_EP   = 13'h0800;
    localparam logic [12:0] S_LM   = 13'h0400;
    localparam logic [12:0] S_CE   = 13'h0200;
    localparam logic [12:0] S_LI   = 13'h0100;
    localparam logic [12:0] S_EI   = 13'h0080;
    localparam logic [12:0] S_LA   = 13'h0040;
    localparam logic [12:0] S_EA   = 13'h0020;
    localparam logic [12:0] S_SU   = 13'h0010;
    localparam logic [12:0] S_EU   = 13'h0008;
    localparam logic [12:0] S_LB   = 13'h0004;
    localparam logic [12:0] S_LO   = 13'h0002;
    localparam logic [12:0] S_HALT = 13'h0001;

    sap1_controller dut (
        .clock   (clock),
        .reset   (reset),
        .opcode  (opcode),
        .t_state (t_state),
        .cp      (cp),
        .ep      (ep),
        .lm      (lm),
        .ce      (ce),
        .li      (li),
        .ei      (ei),
        .la      (la),
        .ea      (ea),
        .su      (su),
        .eu      (eu),
        .lb      (lb),
        .lo      (lo),
        .halt    (halt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [12:0] strobes();
        return {cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo, halt};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [5:0] exp_t, input logic [12:0] exp_s);
        logic [12:0] obs_s;
        obs_s = strobes();
        total++;
        assert (t_state === exp_t) else begin
            bad++;
            $error("FAIL %s t_state got=%b want=%b", tag, t_state, exp_t);
        end
        total++;
        assert (obs_s === exp_s) else begin
            bad++;
            $error("FAIL %s strobes got=%h want=%h", tag, obs_s, exp_s);
        end
        $display("step %s t_state=%b strobes=%h", tag, t_state, obs_s);
    endtask

    initial begin
        int len;
        reset  = 1'b0;
        opcode = 4'h0;

        // Reset held low for three cycles
        tick(); check("rst_c1", 6'b000001, 13'h0);
        tick(); check("rst_c2", 6'b000001, 13'h0);
        tick(); check("rst_c3", 6'b000001, 13'h0);
        reset = 1'b1;
        #1;
        check("rel_t1", 6'b000001, S_EP | S_LM);

        // LDA
        tick(); check("lda_t2", 6'b000010, S_CP);
        tick(); check("lda_t3", 6'b000100, S_CE | S_LI);
        tick(); check("lda_t4", 6'b001000, S_LM | S_EI);
        tick(); check("lda_t5", 6'b010000, S_CE | S_LA);
`ifndef SAP1_EARLY_END_EN
        tick(); check("lda_t6", 6'b100000, 13'h0);
`endif
        tick(); check("lda_wrap", 6'b000001, S_EP | S_LM);

        // ADD
        opcode = 4'h1;
        #1;
        tick(); tick();
        tick(); check("add_t4", 6'b001000, S_LM | S_EI);
        tick(); check("add_t5", 6'b010000, S_CE | S_LB);
        tick(); check("add_t6", 6'b100000, S_LA | S_EU);

        // SUB
        tick(); opcode = 4'h2; #1;
        check("sub_t1", 6'b000001, S_EP | S_LM);
        tick(); tick(); tick();
        check("sub_t4", 6'b001000, S_LM | S_EI);
        tick(); check("sub_t5", 6'b010000, S_CE | S_LB);
        tick(); check("sub_t6", 6'b100000, S_LA | S_EU | S_SU);
        opcode = 4'h1; #1;
        check("sub_to_add_t6", 6'b100000, S_LA | S_EU);

        // OUT: measure machine-cycle length
        tick(); opcode = 4'hE; #1;
        check("out_t1", 6'b000001, S_EP | S_LM);
        tick(); tick(); tick();
        check("out_t4", 6'b001000, S_EA | S_LO);
        len = 3;
        for (int i = 0; i < 12; i++) begin
            tick();
            len++;
            if (t_state == 6'b000001) break;
        end
        total++;
`ifdef SAP1_EARLY_END_EN
        assert (len === 4) else begin
            bad++;
            $error("FAIL out_len got=%0d want=%0d", len, 4);
        end
`else
        assert (len === 6) else begin
            bad++;
            $error("FAIL out_len got=%0d want=%0d", len, 6);
        end
`endif
        $display("step out_len len=%0d", len);

        // Unknown opcode behaves as NOP in execute
        opcode = 4'h7; #1;
        tick(); tick(); tick();
        check("nop_t4", 6'b001000, 13'h0);
`ifdef SAP1_EARLY_END_EN
        tick();
`else
        tick(); tick(); tick();
`endif
        check("nop_wrap", 6'b000001, S_EP | S_LM);

        // Reset during T5 of ADD
        opcode = 4'h1; #1;
        tick(); tick(); tick(); tick();
        check("add2_t5", 6'b010000, S_CE | S_LB);
        reset = 1'b0;
        #1;
        check("mid_rst", 6'b000001, 13'h0);
        tick(); check("mid_rst_hold", 6'b000001, 13'h0);
        reset = 1'b1;
        #1;
        check("refetch_t1", 6'b000001, S_EP | S_LM);
        tick(); check("refetch_t2", 6'b000010, S_CP);
        tick(); check("refetch_t3", 6'b000100, S_CE | S_LI);

        // HLT
        opcode = 4'hF; #1;
        tick(); check("hlt_t4", 6'b001000, S_HALT);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 5) begin
                opcode = 4'h0;
                #1;
            end
            check($sformatf("halted_%0d", i), 6'b001000, S_HALT);
        end
        reset = 1'b0;
        #1;
        check("hlt_rst", 6'b000001, 13'h0);
        tick();
        reset = 1'b1;
        #1;
        check("hlt_rel", 6'b000001, S_EP | S_LM);
        tick(); check("hlt_rel_t2", 6'b000010, S_CP);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap1_controller.md
Name: sap1_controller

Overview:
Controller-sequencer for the SAP-1 datapath. It is the initiator side of the load/enable interface that every datapath register responds to.
- A one-hot ring counter steps through T-states.
- The current T-state and the instruction-register opcode are decoded into the control word (load and enable strobes) that drives the PC, MAR, RAM, IR, A, B, ALU and output register on the shared W bus.

Parameters:
- OPCODE_W, 4, width of opcode field (IR upper nibble)
- RING_W, 6, number of T-states in a full machine cycle (T1..T6)

Ports:
- clock  in  1  system clock; state advances on posedge
- reset  in  1  asynchronous, active-low
- opcode  in  OPCODE_W  IR upper nibble; valid from T4 onward
- t_state  out  RING_W  one-hot ring; bit0 = T1
- cp  out  1  PC increment
- ep  out  1  PC enable onto bus
- lm  out  1  MAR load
- ce  out  1  RAM enable onto bus
- li  out  1  IR load
- ei  out  1  IR address nibble onto bus
- la  out  1  A load
- ea  out  1  A onto bus
- su  out  1  ALU subtract select
- eu  out  1  ALU result onto bus
- lb  out  1  B load
- lo  out  1  output register load
- halt  out  1  processor halted

Behaviour:
- Polarity: all strobes are active-high and one cycle wide. Datapath registers sample them at the posedge that ends the current T-state.
- Reset:
  - reset low: ring = 6'b000001 and halted flag = 0, asynchronously.
  - While reset is low, all control outputs and halt are forced to 0.
  - First T1 strobes appear after reset deasserts.
- Ring: rotates left by one per posedge, T6 -> T1. Exactly one bit is set at all times.
- Control outputs are combinational decodes of ring + opcode + halted (no extra latency).
- Fetch, any opcode:
  - T1: ep, lm
  - T2: cp
  - T3: ce, li
- Opcodes: LDA = 4'h0, ADD = 4'h1, SUB = 4'h2, OUT = 4'hE, HLT = 4'hF.
- Execute states per opcode:
  - LDA: T4 lm, ei; T5 ce, la; T6 none.
  - ADD: T4 lm, ei; T5 ce, lb; T6 la, eu.
  - SUB: as ADD, but T6 la, eu, su.
  - OUT: T4 ea, lo; T5, T6 none.
  - Unknown opcode: T4..T6 none (NOP).
- HLT:
  - In T4 with opcode HLT, halt asserts combinationally.
  - At that posedge the halted flag sets and the ring freezes at T4.
  - While halted: halt = 1 and all other strobes are 0.
  - Only reset leaves the halted state.
- Bus exclusivity: at most one of ep, ce, ei, ea, eu is high in any state (asserted property).
- Opcode changes mid-execute follow the current value combinationally. IR stability from T4 to end of cycle is the datapath's responsibility.

Optional Feature:
- Macro: SAP1_EARLY_END_EN
- Defined: variable machine cycle. The ring returns to T1 after the last useful state instead of continuing:
  - LDA: after T5
  - ADD/SUB: after T6 (unchanged)
  - OUT and unknown opcodes: after T4
  - HLT: unaffected
- Undefined: every instruction takes exactly 6 states.

Decomposition:
- Package sap1_pkg holds:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT)
  - T-state index constants
  - a packed control-word typedef with field order cp, ep, lm, ce, li, ei, la, ea, su, eu, lb, lo
- Sub-module sap1_ring_counter holds the one-hot ring, halt freeze, early-end restart input and async reset.
- The top module is a decode of ring plus opcode into the control word.

Test Plan:
- Reset: hold reset low 3 cycles, then release -> t_state = 000001, all strobes 0 during reset. First cycle after release: ep = lm = 1.
- LDA (opcode = 0): run 6 cycles -> T1 {ep,lm}, T2 {cp}, T3 {ce,li}, T4 {lm,ei}, T5 {ce,la}, T6 {}, then t_state = 000001.
- SUB (opcode = 2): T6 -> la = eu = su = 1, lb = 0. ADD (opcode = 1) at T6 -> su = 0.
- HLT (opcode = F): at T4, halt = 1. Over next 10 cycles, t_state stays 001000, halt = 1, other strobes 0. Pulse reset -> halt = 0, T1.
- Reset mid-T5 of ADD -> immediate t_state = 000001, strobes 0. After release, fetch restarts cleanly.
- With SAP1_EARLY_END_EN, opcode OUT = E -> T4 {ea,lo}, next state T1, cycle length 4. Without the macro -> length 6.
